// File: rtl/fmul_arbiter_if.sv
// Bundle of requester, multiplier and response signals for fmul_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fmul_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [31:0] mul_result;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        proto_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  mul_ready, mul_result,
        output req0_ready, req1_ready, mul_start, mul_a, mul_b,
        output rsp0_valid, rsp1_valid, rsp_data, busy, proto_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output mul_ready, mul_result,
        input  req0_ready, req1_ready, mul_start, mul_a, mul_b,
        input  rsp0_valid, rsp1_valid, rsp_data, busy, proto_err
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Two-port round-robin front end for a pipelined FP multiplier.
// Issues one op per cycle, tracks requester ids through a tag pipeline
// matched to the multiplier latency, and routes results back as pulses.
module fmul_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    fmul_arbiter_if.slave  bus
);
    // r_prio: 0 -> port 0 wins a tie, 1 -> port 1 wins a tie
    logic               r_prio;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_xfer;
    logic               w_emerge;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    // Stage 0 is the issue register itself (mul_start), stage LATENCY lines up
    // with the multiplier's mul_ready for that op.
    logic [LATENCY:0]   r_vld_pipe;
    logic [LATENCY:0]   r_id_pipe;
    logic               r_rsp0;
    logic               r_rsp1;
    logic [31:0]        r_data;
    logic               r_err;

    // Grant: lone valid wins; on a tie the pointer decides. Reset blocks grants.
    always_comb begin
        w_gnt0 = !rst && bus.req0_valid && (!bus.req1_valid || !r_prio);
        w_gnt1 = !rst && bus.req1_valid && (!bus.req0_valid ||  r_prio);
    end

    assign w_xfer   = w_gnt0 | w_gnt1;
    assign w_emerge = r_vld_pipe[LATENCY];

    // Pointer flips away from whoever was just served, only on a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio <= 1'b0;
        else if (w_xfer)
            r_prio <= w_gnt0;
    end

    // Issue register and tag pipeline; the pipe shifts every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_vld_pipe[0]         <= w_xfer;
            r_id_pipe[0]          <= w_gnt1;
            r_vld_pipe[LATENCY:1] <= r_vld_pipe[LATENCY-1:0];
            r_id_pipe[LATENCY:1]  <= r_id_pipe[LATENCY-1:0];
            if (w_xfer) begin
                r_a <= w_gnt1 ? bus.req1_a : bus.req0_a;
                r_b <= w_gnt1 ? bus.req1_b : bus.req0_b;
            end
        end
    end

    // Response capture: a tag/ready disagreement in either direction is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0 <= 1'b0;
            r_rsp1 <= 1'b0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_rsp0 <= w_emerge && bus.mul_ready && !r_id_pipe[LATENCY];
            r_rsp1 <= w_emerge && bus.mul_ready &&  r_id_pipe[LATENCY];
            if (w_emerge && bus.mul_ready)
                r_data <= bus.mul_result;
            if (w_emerge != bus.mul_ready)
                r_err <= 1'b1;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.mul_start  = r_vld_pipe[0];
    assign bus.mul_a      = r_a;
    assign bus.mul_b      = r_b;
    assign bus.rsp0_valid = r_rsp0;
    assign bus.rsp1_valid = r_rsp1;
    assign bus.rsp_data   = r_data;
    assign bus.busy       = |r_vld_pipe;
    assign bus.proto_err  = r_err;
endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter with a latency-accurate multiplier model
// returning hand-computed IEEE-754 products for a fixed vector set.
module tb_fmul_arbiter;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmul_arbiter_if bus();
    fmul_arbiter #(.LATENCY(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { int due; logic id; logic [31:0] data; } exp_t;
    typedef struct { int due; logic rdy; logic [31:0] res; } mul_t;
    exp_t        sb[$];
    mul_t        mq[$];
    logic [63:0] pq0[$];
    logic [63:0] pq1[$];
    logic        gq[$];
    bit          suppress_next = 0;
    bit          drop_next = 0;
    bit          acc0 = 0, acc1 = 0, prev_acc = 0;
    logic [31:0] prev_a = '0, prev_b = '0;

    logic [31:0] va [8] = '{32'h40000000, 32'hBF000000, 32'h3F800000, 32'h40000000,
                            32'h3FC00000, 32'h3F000000, 32'hBF800000, 32'h40800000};
    logic [31:0] vb [8] = '{32'h40400000, 32'h40CCCCCD, 32'h3F800000, 32'h40000000,
                            32'h40000000, 32'h3F000000, 32'h40400000, 32'h3E800000};

    // Hand-computed products of the vector set
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000; //  2.0 *  3.0 =  6.0
            64'hBF000000_40CCCCCD: return 32'hC04CCCCD; // -0.5 *  6.4 = -3.2
            64'h3F800000_3F800000: return 32'h3F800000; //  1.0 *  1.0 =  1.0
            64'h40000000_40000000: return 32'h40800000; //  2.0 *  2.0 =  4.0
            64'h3FC00000_40000000: return 32'h40400000; //  1.5 *  2.0 =  3.0
            64'h3F000000_3F000000: return 32'h3E800000; //  0.5 *  0.5 = 0.25
            64'hBF800000_40400000: return 32'hC0400000; // -1.0 *  3.0 = -3.0
            64'h40800000_3E800000: return 32'h3F800000; //  4.0 * 0.25 =  1.0
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " req0_ready"}, bus.req0_ready, 0);
        chk({tag, " req1_ready"}, bus.req1_ready, 0);
        chk({tag, " mul_start"},  bus.mul_start, 0);
        chk({tag, " mul_a"},      bus.mul_a, 0);
        chk({tag, " mul_b"},      bus.mul_b, 0);
        chk({tag, " rsp0_valid"}, bus.rsp0_valid, 0);
        chk({tag, " rsp1_valid"}, bus.rsp1_valid, 0);
        chk({tag, " rsp_data"},   bus.rsp_data, 0);
        chk({tag, " busy"},       bus.busy, 0);
        chk({tag, " proto_err"},  bus.proto_err, 0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers and multiplier model, driven just after the edge
    always @(posedge clk) begin
        mul_t m;
        #1;
        if (acc0 && pq0.size() > 0) void'(pq0.pop_front());
        if (acc1 && pq1.size() > 0) void'(pq1.pop_front());
        bus.req0_valid = (pq0.size() > 0);
        if (pq0.size() > 0) {bus.req0_a, bus.req0_b} = pq0[0];
        bus.req1_valid = (pq1.size() > 0);
        if (pq1.size() > 0) {bus.req1_a, bus.req1_b} = pq1[0];
        bus.mul_ready = 1'b0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            bus.mul_ready  = m.rdy;
            bus.mul_result = m.res;
        end
    end

    // Monitor: accepts, issue check, multiplier capture, response scoreboard
    always @(negedge clk) begin
        logic        g;
        logic [31:0] a, b;
        exp_t        e;
        if (rst) begin
            acc0 = 0; acc1 = 0; prev_acc = 0;
        end else begin
            chk("mul_start", bus.mul_start, prev_acc);
            if (prev_acc) begin
                chk("mul_a", bus.mul_a, prev_a);
                chk("mul_b", bus.mul_b, prev_b);
            end
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            if (acc0 && acc1) chk("one_ready", 1, 0);
            if (acc0 || acc1) begin
                g = acc1;
                a = acc1 ? bus.req1_a : bus.req0_a;
                b = acc1 ? bus.req1_b : bus.req0_b;
                if (gq.size() > 0) chk("grant", g, gq.pop_front());
                if (drop_next) drop_next = 0;
                else sb.push_back(exp_t'{cyc + L + 2, g, fmul_ref(a, b)});
                prev_a = a; prev_b = b;
            end
            prev_acc = acc0 || acc1;
            if (bus.mul_start) begin
                mq.push_back(mul_t'{cyc + L, !suppress_next, fmul_ref(bus.mul_a, bus.mul_b)});
                suppress_next = 0;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (bus.rsp0_valid && bus.rsp1_valid) chk("rsp_both", 1, 0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got pulse rsp0=%b rsp1=%b, required none (cycle %0d)",
                             bus.rsp0_valid, bus.rsp1_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", bus.rsp1_valid, e.id);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_cycle", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                checks++; errors++;
                $display("FAIL rsp_missing: got no pulse, required id %0d data %h at cycle %0d",
                         e.id, e.data, e.due);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk); #2;
        rst = 1'b1;
        pq0.delete(); pq1.delete(); sb.delete(); gq.delete();
        drop_next = 0;
        #1 check_zero("reset");
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #2;
            if (pq0.size() == 0 && pq1.size() == 0 && sb.size() == 0 &&
                mq.size() == 0 && !bus.busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout: got busy=%b sb=%0d, required idle", bus.busy, sb.size());
    endtask

    initial begin
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0;
        bus.mul_ready  = 0; bus.mul_result = '0;
        @(negedge clk); #1 check_zero("por");
        #1 rst = 1'b0;

        // Single op on port 0
        reset_dut();
        gq.push_back(0);
        pq0.push_back({va[0], vb[0]});
        wait_idle();
        chk("hold_data", bus.rsp_data, 32'h40C00000);
        chk("no_err_single", bus.proto_err, 0);

        // Simultaneous requests right after reset: port 0 first
        reset_dut();
        gq.push_back(0); gq.push_back(1);
        pq0.push_back({va[0], vb[0]});
        pq1.push_back({va[1], vb[1]});
        wait_idle();
        chk("hold_data2", bus.rsp_data, 32'hC04CCCCD);

        // Fairness: 8 ops per port, continuously valid
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            pq0.push_back({va[i], vb[i]});
            pq1.push_back({va[7-i], vb[7-i]});
            gq.push_back(0); gq.push_back(1);
        end
        wait_idle();
        chk("fair_grants_left", gq.size(), 0);
        chk("no_err_fair", bus.proto_err, 0);

        // Protocol error: multiplier drops the first op, second still returns
        reset_dut();
        chk("err_clear", bus.proto_err, 0);
        suppress_next = 1; drop_next = 1;
        gq.push_back(0); gq.push_back(1);
        pq0.push_back({va[2], vb[2]});
        pq1.push_back({va[3], vb[3]});
        wait_idle();
        chk("err_set", bus.proto_err, 1);
        repeat (5) @(negedge clk);
        #2 chk("err_sticky", bus.proto_err, 1);

        // Reset mid-flight: in-flight tags discarded, late returns flag error
        reset_dut();
        pq0.push_back({va[4], vb[4]});
        pq0.push_back({va[5], vb[5]});
        for (int i = 0; i < 50 && sb.size() < 2; i++) @(negedge clk);
        chk("midflight_issued", sb.size(), 2);
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        pq0.delete(); sb.delete();
        #1 check_zero("midflight");
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #2;
        chk("busy_after_release", bus.busy, 0);
        wait_idle();
        chk("late_return_err", bus.proto_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, cycles from mul_start high to matching mul_ready/mul_result from the pipelined FP multiplier.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a multiply pending.
REQ-005 req0_a, req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-006 req0_ready  output  1  requester 0 accepted this cycle.
REQ-007 req1_valid / req1_a / req1_b / req1_ready  same as REQ-004..006 for requester 1.
REQ-008 mul_start  output  1  issue pulse to multiplier.
REQ-009 mul_a, mul_b  output  32 each  operands to multiplier, valid while mul_start=1.
REQ-010 mul_ready  input  1  multiplier result valid.
REQ-011 mul_result  input  32  multiplier product.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  one-cycle result pulse to requester 0 / 1.
REQ-013 rsp_data  output  32  product, valid with either rsp valid.
REQ-014 busy  output  1  any operation issued and not yet returned.
REQ-015 proto_err  output  1  sticky: expected result missing.

Function
REQ-016 Handshake: transfer when reqN_valid && reqN_ready at a rising edge; reqN_ready combinational from valids and priority pointer; at most one ready high per cycle; requesters hold valid/operands until accepted.
REQ-017 Arbitration: round-robin; one valid -> that port granted; both valid -> port other than last granted; pointer updates only on a transfer.
REQ-018 Issue: transfer at edge E -> mul_start=1, mul_a/mul_b = accepted operands during cycle after E; mul_start=0 otherwise; one issue per cycle max, back-to-back allowed (full throughput).
REQ-019 Tag pipeline: LATENCY-deep shift register of {valid, id}; entry enters with mul_start, emerges exactly LATENCY cycles later.
REQ-020 Response: in emerge cycle, if tag valid and mul_ready=1 -> rspID_valid=1 and rsp_data=mul_result registered, visible next cycle (total request-to-response = LATENCY+2 cycles from E); other rsp valid stays 0.
REQ-021 Tag valid with mul_ready=0 -> proto_err set, no rsp pulse, tag dropped; mul_ready=1 with no valid tag -> ignored, proto_err set.
REQ-022 No response backpressure; responses return in issue order.
REQ-023 busy = mul_start OR any valid tag in pipeline OR rsp pending registration.
REQ-024 rsp_data holds last delivered value when no rsp valid.
REQ-025 No arithmetic on operands/result; data passes bit-exact.

Reset
REQ-026 rst high -> immediately: req0_ready=req1_ready=0, mul_start=0, mul_a=mul_b=0, all tags invalid, rsp0_valid=rsp1_valid=0, rsp_data=0, busy=0, proto_err=0, pointer = port 0 preferred.
REQ-027 Reset mid-operation discards in-flight tags; mul_ready pulses after reset release for pre-reset issues yield no rsp pulse and do not set proto_err only if they arrive while rst high; after release they set proto_err (REQ-021).
REQ-028 First cycle after rst deassert: both valid -> port 0 granted.

Verification
REQ-029 Single op: port0 0x40000000 x 0x40400000, multiplier model LATENCY=4 -> mul_start one cycle after accept, rsp0_valid pulse 6 cycles after accept, rsp_data=0x40C00000, rsp1_valid stays 0.
REQ-030 Simultaneous: port0 2.0x3.0, port1 0xBF000000 x 0x40CCCCCD in same cycle after reset -> port0 first, port1 next cycle; rsp0 0x40C00000 then rsp1 0xC04CCCCD on consecutive cycles.
REQ-031 Fairness: both ports valid continuously for 8 ops each -> grants alternate 0,1,0,1..., one mul_start every cycle, 16 responses in issue order, correct ids.
REQ-032 Reset mid-flight: two ops issued, rst asserted 2 cycles later for 1 cycle -> all outputs 0 at once, no rsp pulses, busy=0 after release.
REQ-033 Protocol error: model suppresses mul_ready for one issued op -> proto_err=1 in cycle after emerge, no rsp for that op, later ops still returned correctly; proto_err held until rst.
